// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory path: loader state encoding
// and the imem geometry used by both the loader and the core's fetch port.
package riscv_pkg;

   localparam int IMEM_ADDR_W  = 8;
   localparam int IMEM_DATA_W  = 32;
   localparam int LOADER_CNT_W = 16;

   typedef enum logic [2:0] {
      ST_CNT_LO,
      ST_CNT_HI,
      ST_DATA,
      ST_CSUM,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes, LSB first, into 32-bit words and emits a one-cycle
// word_valid pulse aligned with the completed word on o_word.
module imem_word_assembler
   import riscv_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clear,
   input  logic                   i_byte_valid,
   input  logic [7:0]             i_byte,
   input  logic                   i_wr_en,
   output logic                   o_lane_last,
   output logic                   o_word_valid,
   output logic [IMEM_DATA_W-1:0] o_word
);

   logic [1:0]             r_lane;
   logic [23:0]            r_shift;
   logic [IMEM_DATA_W-1:0] r_word;
   logic                   r_word_valid;

   // o_word only changes when a word completes, so it stays stable between writes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lane       <= '0;
         r_shift      <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clear) begin
            r_lane <= '0;
         end else if (i_byte_valid) begin
            if (r_lane == 2'd3) begin
               r_word       <= {i_byte, r_shift};
               r_word_valid <= i_wr_en;
               r_lane       <= '0;
            end else begin
               r_shift <= {i_byte, r_shift[23:8]};
               r_lane  <= r_lane + 2'd1;
            end
         end
      end
   end

   assign o_lane_last  = (r_lane == 2'd3);
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

endmodule

// File: rtl/imem_stream_loader.sv
// Streams a counted byte image into imem and holds the core in reset until the
// load finishes cleanly. Trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CNT_LO    | waiting for word-count low byte
// CNT_HI    | waiting for word-count high byte
// DATA      | assembling and writing data words
// CSUM      | waiting for checksum byte (checksum build only)
// DONE      | load finished; core released if no error; waits for reload
module imem_stream_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int CNT_W  = LOADER_CNT_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx_valid,
   input  logic [7:0]             i_rx_data,
   output logic                   o_rx_ready,
   input  logic                   i_reload,
   output logic                   o_imem_we,
   output logic [ADDR_W-1:0]      o_imem_addr,
   output logic [IMEM_DATA_W-1:0] o_imem_wdata,
   output logic                   o_cpu_rst,
   output logic                   o_load_done,
   output logic                   o_load_err
);

   localparam logic [CNT_W:0] CAPACITY = (CNT_W+1)'(1) << ADDR_W;

   loader_state_t     r_state;
   logic              r_rx_ready;
   logic [ADDR_W-1:0] r_imem_addr;
   logic              r_cpu_rst;
   logic              r_load_done;
   logic              r_load_err;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_index;

   logic              w_accept;
   logic              w_data_byte;
   logic              w_lane_last;
   logic              w_word_end;
   logic              w_in_range;
   logic              w_last_word;
   logic              w_err_now;
   logic              w_clear;
   logic [CNT_W:0]    w_index_inc;

   assign w_accept    = i_rx_valid && r_rx_ready;
   assign w_data_byte = w_accept && (r_state == ST_DATA);
   assign w_word_end  = w_data_byte && w_lane_last;
   assign w_in_range  = ({1'b0, r_index} < CAPACITY);
   assign w_index_inc = {1'b0, r_index} + (CNT_W+1)'(1);
   assign w_last_word = (w_index_inc == {1'b0, r_count});
   assign w_err_now   = r_load_err || (w_word_end && !w_in_range);
   assign w_clear     = (r_state == ST_DONE) && i_reload;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_csum;
   logic       w_csum_bad;
   assign w_csum_bad = (i_rx_data != r_csum);
`endif

   imem_word_assembler u_asm (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (w_clear),
      .i_byte_valid (w_data_byte),
      .i_byte       (i_rx_data),
      .i_wr_en      (w_in_range),
      .o_lane_last  (w_lane_last),
      .o_word_valid (o_imem_we),
      .o_word       (o_imem_wdata)
   );

   // cpu_rst mirrors the error flag on entry to DONE so release happens in the first DONE cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_CNT_LO;
         r_rx_ready  <= 1'b1;
         r_imem_addr <= '0;
         r_cpu_rst   <= 1'b1;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
         r_count     <= '0;
         r_index     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         case (r_state)
            ST_CNT_LO: begin
               if (w_accept) begin
                  r_count[7:0] <= i_rx_data;
                  r_state      <= ST_CNT_HI;
               end
            end
            ST_CNT_HI: begin
               if (w_accept) begin
                  r_count[CNT_W-1:8] <= i_rx_data;
                  if ({i_rx_data, r_count[7:0]} == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state     <= ST_CSUM;
`else
                     r_state     <= ST_DONE;
                     r_rx_ready  <= 1'b0;
                     r_load_done <= 1'b1;
                     r_cpu_rst   <= r_load_err;
`endif
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (w_data_byte) begin
                  r_csum <= r_csum + i_rx_data;
               end
`endif
               if (w_word_end) begin
                  if (w_in_range) begin
                     r_imem_addr <= r_index[ADDR_W-1:0];
                  end else begin
                     r_load_err <= 1'b1;
                  end
                  r_index <= w_index_inc[CNT_W-1:0];
                  if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state     <= ST_CSUM;
`else
                     r_state     <= ST_DONE;
                     r_rx_ready  <= 1'b0;
                     r_load_done <= 1'b1;
                     r_cpu_rst   <= w_err_now;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (w_accept) begin
                  r_load_err  <= r_load_err || w_csum_bad;
                  r_state     <= ST_DONE;
                  r_rx_ready  <= 1'b0;
                  r_load_done <= 1'b1;
                  r_cpu_rst   <= r_load_err || w_csum_bad;
               end
            end
`endif
            ST_DONE: begin
               if (i_reload) begin
                  r_state     <= ST_CNT_LO;
                  r_rx_ready  <= 1'b1;
                  r_cpu_rst   <= 1'b1;
                  r_load_done <= 1'b0;
                  r_load_err  <= 1'b0;
                  r_count     <= '0;
                  r_index     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum      <= '0;
`endif
               end
            end
            default: r_state <= ST_CNT_LO;
         endcase
      end
   end

   assign o_rx_ready  = r_rx_ready;
   assign o_imem_addr = r_imem_addr;
   assign o_cpu_rst   = r_cpu_rst;
   assign o_load_done = r_load_done;
   assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader with a 4-word imem so overflow is reachable;
// expected writes and error flags come from the stream rules, not the RTL.
module tb_imem_stream_loader;

   localparam int ADDR_W = 2;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              reload;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              load_done;
   logic              load_err;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+31:0] got_q[$];
   logic [ADDR_W+31:0] exp_q[$];
   logic [31:0]        words[$];
   logic [7:0]         stream[$];
   int                 dbl_we;
   logic               prev_we = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
   bit                 corrupt = 1'b0;
`endif

   imem_stream_loader #(.ADDR_W(ADDR_W)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx_valid   (rx_valid),
      .i_rx_data    (rx_data),
      .o_rx_ready   (rx_ready),
      .i_reload     (reload),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_wdata (imem_wdata),
      .o_cpu_rst    (cpu_rst),
      .o_load_done  (load_done),
      .o_load_err   (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) begin
         got_q.push_back({imem_addr, imem_wdata});
         if (prev_we) dbl_we++;
      end
      prev_we = imem_we;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 1);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_cpu_rst"}, cpu_rst, 1);
      check({tag, "_load_done"}, load_done, 0);
      check({tag, "_load_err"}, load_err, 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      t = 0;
      while (rx_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t == 20) check("rx_ready_wait", rx_ready, 1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // count header, words LSB first, optional modulo-256 sum of data bytes
   task automatic make_stream();
      logic [7:0]  sum;
      logic [15:0] n;
      n = 16'(words.size());
      sum = 8'h00;
      stream.delete();
      stream.push_back(n[7:0]);
      stream.push_back(n[15:8]);
      foreach (words[i]) begin
         for (int k = 0; k < 4; k++) begin
            stream.push_back(words[i][8*k +: 8]);
            sum = sum + words[i][8*k +: 8];
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(corrupt ? sum + 8'd1 : sum);
`endif
      if (sum == 8'h00) begin end
   endtask

   task automatic run_load(input string tag, input int gap_max);
      logic exp_err;
      make_stream();
      exp_q.delete();
      foreach (words[i])
         if (i < CAP) exp_q.push_back({ADDR_W'(i), words[i]});
      exp_err = (words.size() > CAP);
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = exp_err || corrupt;
`endif
      got_q.delete();
      dbl_we = 0;
      check({tag, "_pre_done"}, load_done, 0);
      check({tag, "_pre_cpu_rst"}, cpu_rst, 1);
      for (int i = 0; i < stream.size() - 1; i++)
         send_byte(stream[i], $urandom_range(gap_max, 0));
      check({tag, "_done_before_last"}, load_done, 0);
      send_byte(stream[stream.size()-1], $urandom_range(gap_max, 0));
      check({tag, "_done"}, load_done, 1);
      check({tag, "_cpu_rst"}, cpu_rst, exp_err);
      check({tag, "_err"}, load_err, exp_err);
      check({tag, "_rx_ready"}, rx_ready, 0);
      repeat (3) @(negedge clk);
      #1;
      check({tag, "_nwrites"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
      check({tag, "_double_we"}, dbl_we, 0);
   endtask

   task automatic reload_pulse(input string tag);
      @(negedge clk);
      reload = 1'b1;
      @(posedge clk);
      #1 reload = 1'b0;
      check({tag, "_cpu_rst"}, cpu_rst, 1);
      check({tag, "_done"}, load_done, 0);
      check({tag, "_err"}, load_err, 0);
      check({tag, "_rx_ready"}, rx_ready, 1);
   endtask

   task automatic random_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      reload   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      words = '{32'h0000_0013, 32'h0010_0093};
      run_load("n2", 0);
      reload_pulse("reload1");

      run_load("n2_gaps", 7);
      reload_pulse("reload2");

      words.delete();
      run_load("n0", 2);
      check("n0_rx_ready_hold", rx_ready, 0);
      reload_pulse("reload3");

      random_words(5);
      run_load("ovf", 1);
      reload_pulse("reload4");

`ifdef IMEM_LOADER_CHECKSUM_EN
      words = '{32'h0403_0201};
      corrupt = 1'b0;
      run_load("csum_ok", 1);
      reload_pulse("reload5");
      corrupt = 1'b1;
      run_load("csum_bad", 1);
      reload_pulse("reload6");
      corrupt = 1'b0;
`endif

      random_words(3);
      make_stream();
      for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
      #2 rst = 1'b1;
      #1 check_reset_vals("abort");
      @(negedge clk);
      rst = 1'b0;
      random_words(3);
      run_load("after_abort", 3);
      reload_pulse("reload7");

      for (int it = 0; it < 6; it++) begin
         random_words($urandom_range(6, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
         corrupt = $urandom_range(1, 0);
`endif
         run_load($sformatf("rand%0d", it), 3);
         reload_pulse($sformatf("rand%0d_reload", it));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Writer side of the processor's instruction memory: the processor only reads imem during fetch, and this block fills it.
- Consumes a byte stream with a valid/ready handshake, assembles 32-bit little-endian words and writes them into the imem write port.
- Holds the RISC-V core in reset until the load completes cleanly, then releases it.
- Replaces hard-coded memory init for bring-up and for bench-driven program loading.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2**ADDR_W words.
- CNT_W, 16, width of the word-count header; fixed at 16, the header is always 2 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at a rising edge.
- reload  in  1  one-cycle request to restart loading; honoured only in DONE.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  imem write data.
- cpu_rst  out  1  reset to the core, active-high.
- load_done  out  1  load sequence finished.
- load_err  out  1  load failed (overflow, or checksum mismatch when enabled).

Behaviour:
- Reset values:
  - state=CNT_LO, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=1, load_done=0, load_err=0.
  - word counter, byte lane and checksum all 0.
- Stream format:
  - count_lo, count_hi (N = 16-bit word count, little-endian).
  - Then 4*N data bytes, each word LSB first.
  - With CHECKSUM_EN, one trailing checksum byte.
- States:
  - CNT_LO: accept a byte → latch count[7:0] → CNT_HI.
  - CNT_HI: accept a byte → latch count[15:8]. If N==0 go to CSUM (macro defined) or DONE; else go to DATA.
  - DATA: each accepted byte fills lane 0..3 of the assembly register.
    - On lane 3: register a write. imem_we=1 and imem_wdata={b3,b2,b1,b0} are valid the cycle after the 4th byte is accepted. imem_addr = word index (starts at 0).
    - After the write: word index increments, lane returns to 0.
    - After word N-1 is accepted: go to CSUM or DONE.
  - CSUM: present only with the macro; see Optional Feature.
  - DONE: rx_ready=0, load_done=1. cpu_rst=0 only if load_err==0; on any error cpu_rst stays 1.
    - reload=1 → CNT_LO next cycle. That same edge sets cpu_rst=1 and clears load_done, load_err, counters and checksum.
- rx_ready=1 in every state except DONE. The loader never applies backpressure mid-load; rx_valid gaps of any length are tolerated with no timeout.
- load_done and the cpu_rst deassertion both occur in the first cycle in DONE. The last imem write completes no later than that cycle.
- Overflow: a word index ≥ 2**ADDR_W suppresses imem_we for that word. Its bytes are still consumed, the stream still completes, and load_err is set (sticky until reload/rst).
- imem_addr holds its last value between writes. imem_we is never asserted for more than one consecutive cycle per word.
- reload outside DONE is ignored.
- rst asserted mid-load aborts immediately to reset values. The partial imem contents are left as written.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - CSUM state exists. The checksum is the 8-bit modulo-256 sum of all data bytes; count bytes are excluded.
  - The accepted byte in CSUM is compared with the sum. On mismatch, load_err=1.
  - Then DONE.
- Undefined:
  - No CSUM state, no checksum logic.
  - Stream ends after the last data byte.
  - load_err reflects overflow only.

Decomposition:
- Shared package riscv_pkg holds:
  - the loader state enum (CNT_LO, CNT_HI, DATA, CSUM, DONE);
  - IMEM_ADDR_W and the word width 32, used by both loader and core imem;
  - LOADER_CNT_W=16.
- Sub-module imem_word_assembler: byte-lane counter plus 32-bit shift/assembly register with a word_valid pulse. This is natural to split and reusable for data-memory loading.

Test Plan:
- Load N=2, bytes 13 00 00 00 / 93 00 10 00 → imem_we pulses at addr 0 (0x00000013) and addr 1 (0x00100093). cpu_rst falls and load_done rises in the same cycle.
- Same stream with random rx_valid gaps of 0–7 cycles → identical writes and addresses, no extra imem_we pulses.
- N=0 (macro off) → DONE two accepted bytes after reset, no imem_we, cpu_rst=0.
- ADDR_W=2, N=5 → writes at addr 0..3 only, 5th word consumed without a write, load_err=1, cpu_rst stays 1.
- With IMEM_LOADER_CHECKSUM_EN, N=1, data 01 02 03 04:
  - checksum 0x0A → load_err=0, cpu_rst=0;
  - checksum 0x0B → load_err=1, cpu_rst=1.
- rst pulse after 6 data bytes, then a full reload stream → outputs return to reset values asynchronously. The second load writes from addr 0; in DONE, a reload pulse reasserts cpu_rst the next cycle.
